// File: rtl/fp_div_pkg.sv
// Shared definitions for the parameterised floating-point divider: FSM encoding,
// default field widths, special-result kinds and flag bit positions.
package fp_div_pkg;

  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UNPACK = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_ROUND  = 2'd3;

  // SPC_NAN packs to all ones (sign included), SPC_INF to {sign, all ones},
  // SPC_ZERO to signed zero; SPC_NONE takes the rounded quotient.
  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF,
    SPC_ZERO
  } special_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fp_div_round.sv
// Normalise, round-to-nearest-even and pack the raw restoring-division quotient;
// out-of-range exponents flush to signed zero or saturate to {sign, all ones}.
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [MAN_W+2:0]        quo,
  input  logic                    rem_nz,
  output logic [EXP_W+MAN_W:0]    result,
  output logic                    overflow,
  output logic                    underflow
);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 2);
  localparam logic signed [EXP_W+1:0] ONE     = (EXP_W+2)'(1);

  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [MAN_W:0]          man;
  logic [MAN_W+1:0]        man_r;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] exp_f;

  // NOTE: every branch below assigns every output, so no latch is inferred.
  always_comb begin
    // Quotient lies in [0.5, 2): the top bit tells whether a one-place shift is needed.
    if (quo[MAN_W+2]) begin
      man    = quo[MAN_W+2:2];
      guard  = quo[1];
      sticky = quo[0] | rem_nz;
      exp_n  = exp_in;
    end else begin
      man    = quo[MAN_W+1:1];
      guard  = quo[0];
      sticky = rem_nz;
      exp_n  = exp_in - ONE;
    end
    round_up = guard & (sticky | man[0]);
    man_r    = {1'b0, man} + {{(MAN_W+1){1'b0}}, round_up};
    if (man_r[MAN_W+1]) begin
      exp_f = exp_n + ONE;
      frac  = man_r[MAN_W:1];
    end else begin
      exp_f = exp_n;
      frac  = man_r[MAN_W-1:0];
    end
    underflow = exp_f < ONE;
    overflow  = exp_f > EXP_MAX;
    if (underflow)     result = {sign, {(EXP_W+MAN_W){1'b0}}};
    else if (overflow) result = {sign, {(EXP_W+MAN_W){1'b1}}};
    else               result = {sign, exp_f[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp_div_param.sv
// Multi-cycle floating-point divider, one restoring quotient bit per cycle.
// Optional flags output enabled by defining FP_DIV_FLAGS_EN.
module fp_div_param
  import fp_div_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  input  logic [EXP_W+MAN_W:0] data_dividend,
  input  logic [EXP_W+MAN_W:0] data_divisor,
  output logic                 output_update,
  output logic                 idle,
  output logic [EXP_W+MAN_W:0] data_q
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0]           LAST_ITER = CW'(QW - 1);
  localparam logic signed [EXP_W+1:0] BIAS      = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);

  logic [1:0]              state;
  logic [CW-1:0]           iter_cnt;
  logic [W-1:0]            op_a, op_b;
  logic                    res_sign;
  logic signed [EXP_W+1:0] res_exp;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W+1:0]        rem_diff;
  logic [MAN_W:0]          div_man;
  logic [QW-1:0]           quo;
  special_e                special, special_d;
  logic [EXP_W-1:0]        exp_a, exp_b;
  logic [W-1:0]            rnd_result, result;
  logic                    rnd_ovf, rnd_unf;

  assign idle     = (state == S_IDLE);
  assign exp_a    = op_a[W-2:MAN_W];
  assign exp_b    = op_b[W-2:MAN_W];
  assign rem_diff = rem - {1'b0, div_man};

  // Subnormals count as zero; an all-ones exponent anywhere poisons the result.
  always_comb begin
    special_d = SPC_NONE;
    if ((&exp_a) || (&exp_b) || (exp_a == '0 && exp_b == '0)) special_d = SPC_NAN;
    else if (exp_b == '0)                                      special_d = SPC_INF;
    else if (exp_a == '0)                                      special_d = SPC_ZERO;
  end

  // NOTE: datapath registers carry no reset; the FSM guarantees they are loaded before use.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (input_valid) begin
        op_a <= data_dividend;
        op_b <= data_divisor;
      end
      S_UNPACK: begin
        res_sign <= op_a[W-1] ^ op_b[W-1];
        res_exp  <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;
        rem      <= {2'b01, op_a[MAN_W-1:0]};
        div_man  <= {1'b1, op_b[MAN_W-1:0]};
        quo      <= '0;
        special  <= special_d;
      end
      S_ITER: begin
        if (rem >= {1'b0, div_man}) begin
          rem <= {rem_diff[MAN_W:0], 1'b0};
          quo <= {quo[QW-2:0], 1'b1};
        end else begin
          rem <= {rem[MAN_W:0], 1'b0};
          quo <= {quo[QW-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  fp_div_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign      (res_sign),
    .exp_in    (res_exp),
    .quo       (quo),
    .rem_nz    (|rem),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  always_comb begin
    result = rnd_result;
    case (special)
      SPC_NAN:  result = '1;
      SPC_INF:  result = {res_sign, {(W-1){1'b1}}};
      SPC_ZERO: result = {res_sign, {(W-1){1'b0}}};
      default:  ;
    endcase
  end

`ifdef FP_DIV_FLAGS_EN
  logic [3:0] flags_d;
  always_comb begin
    flags_d                 = '0;
    flags_d[FLAG_INVALID]   = (special == SPC_NAN);
    flags_d[FLAG_DIV_ZERO]  = (special == SPC_INF);
    flags_d[FLAG_OVERFLOW]  = (special == SPC_NONE) && rnd_ovf;
    flags_d[FLAG_UNDERFLOW] = (special == SPC_NONE) && rnd_unf;
  end
`else
  logic unused_flags;
  assign unused_flags = rnd_ovf | rnd_unf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      iter_cnt      <= '0;
      output_update <= 1'b0;
      data_q        <= '0;
`ifdef FP_DIV_FLAGS_EN
      flags         <= '0;
`endif
    end else begin
      output_update <= 1'b0;
      case (state)
        S_IDLE:   if (input_valid) state <= S_UNPACK;
        S_UNPACK: begin
          iter_cnt <= '0;
          state    <= S_ITER;
        end
        S_ITER: begin
          iter_cnt <= iter_cnt + CW'(1);
          if (iter_cnt == LAST_ITER) state <= S_ROUND;
        end
        default: begin
          data_q        <= result;
          output_update <= 1'b1;
          state         <= S_IDLE;
`ifdef FP_DIV_FLAGS_EN
          flags         <= flags_d;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_param.sv
// Directed bench for fp_div_param at FP16: latency, rounding, special values,
// request masking, mid-operation reset and back-to-back requests.
module tb_fp_div_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic [15:0] data_dividend;
  logic [15:0] data_divisor;
  logic        output_update;
  logic        idle;
  logic [15:0] data_q;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int failures = 0;

  fp_div_param dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .data_dividend (data_dividend),
    .data_divisor  (data_divisor),
    .output_update (output_update),
    .idle          (idle),
    .data_q        (data_q)
`ifdef FP_DIV_FLAGS_EN
    ,
    .flags         (flags)
`endif
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    input_valid   = 1'b1;
    data_dividend = a;
    data_divisor  = b;
    @(posedge clk); #1;
    input_valid   = 1'b0;
  endtask

  // Counts edges after the accept edge until output_update, bounded at 40.
  task automatic wait_result(input int start, output int cycles);
    cycles = start;
    while (!output_update && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    input_valid = 1'b0;
    data_dividend = 16'h0;
    data_divisor = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (output_update !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", output_update); end
    checks++; if (data_q !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", data_q); end
`ifdef FP_DIV_FLAGS_EN
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    logic [15:0] va [5] = '{16'h3C00, 16'h3C00, 16'h35C8, 16'h4000, 16'hC000};
    logic [15:0] vb [5] = '{16'h4000, 16'h4200, 16'h16B8, 16'h3C00, 16'h4000};
    logic [15:0] vq [5] = '{16'h3800, 16'h3555, 16'h5AE2, 16'h4000, 16'hBC00};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      checks++; if (idle !== 1'b0) begin failures++; $display("FAIL normal_busy[%0d] got=%b exp=0", i, idle); end
      wait_result(0, cyc);
      checks++; if (cyc !== 15) begin failures++; $display("FAIL normal_latency[%0d] got=%0d exp=15", i, cyc); end
      checks++; if (data_q !== vq[i]) begin failures++; $display("FAIL normal_q[%0d] %h/%h got=%h exp=%h", i, va[i], vb[i], data_q, vq[i]); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL normal_idle[%0d] got=%b exp=1", i, idle); end
`ifdef FP_DIV_FLAGS_EN
      checks++; if (flags !== 4'h0) begin failures++; $display("FAIL normal_flags[%0d] got=%h exp=0", i, flags); end
`endif
    end
  endtask

  task automatic test_special;
    logic [15:0] va [7] = '{16'h5543, 16'h3C00, 16'hD543, 16'h0000, 16'h0000, 16'h8000, 16'h0400};
    logic [15:0] vb [7] = '{16'h128F, 16'h0001, 16'hFFFF, 16'h0000, 16'h3C00, 16'h3C00, 16'h7800};
    logic [15:0] vq [7] = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
    logic [3:0]  vf [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      start_op(va[i], vb[i]);
      wait_result(0, cyc);
      checks++; if (cyc !== 15) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=15", i, cyc); end
      checks++; if (data_q !== vq[i]) begin failures++; $display("FAIL special_q[%0d] %h/%h got=%h exp=%h", i, va[i], vb[i], data_q, vq[i]); end
`ifdef FP_DIV_FLAGS_EN
      checks++; if (flags !== vf[i]) begin failures++; $display("FAIL special_flags[%0d] got=%b exp=%b", i, flags, vf[i]); end
`else
      if (vf[i] === 4'bxxxx) $display("unreachable");
`endif
    end
  endtask

  task automatic test_ignore_busy;
    int cyc;
    start_op(16'h3C00, 16'h4000);
    repeat (2) begin @(posedge clk); #1; end
    input_valid   = 1'b1;
    data_dividend = 16'h4000;
    data_divisor  = 16'h3C00;
    @(posedge clk); #1;
    input_valid   = 1'b0;
    wait_result(3, cyc);
    checks++; if (cyc !== 15) begin failures++; $display("FAIL ignore_latency got=%0d exp=15", cyc); end
    checks++; if (data_q !== 16'h3800) begin failures++; $display("FAIL ignore_q got=%h exp=3800", data_q); end
    @(posedge clk); #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL ignore_no_second_op idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    start_op(16'h3C00, 16'h4200);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
    checks++; if (data_q !== 16'h0000) begin failures++; $display("FAIL midrst_q got=%h exp=0000", data_q); end
    checks++; if (output_update !== 1'b0) begin failures++; $display("FAIL midrst_update got=%b exp=0", output_update); end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (output_update) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_update got=%0d pulses exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(16'h3C00, 16'h4200);
    wait_result(0, cyc);
    checks++; if (data_q !== 16'h3555) begin failures++; $display("FAIL b2b_first_q got=%h exp=3555", data_q); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL b2b_idle_in_update got=%b exp=1", idle); end
    start_op(16'h4000, 16'h3C00);
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b exp=0", idle); end
    checks++; if (data_q !== 16'h3555) begin failures++; $display("FAIL b2b_hold_q got=%h exp=3555", data_q); end
    wait_result(0, cyc);
    checks++; if (cyc !== 15) begin failures++; $display("FAIL b2b_latency got=%0d exp=15", cyc); end
    checks++; if (data_q !== 16'h4000) begin failures++; $display("FAIL b2b_second_q got=%h exp=4000", data_q); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
